// File: rtl/sphere3_point_collector.sv
// sphere3_point_collector
//   Requests points from a sphere3 generator one at a time, captures each
//   point on a rising edge of gen_valid and queues it in a small
//   first-word-fall-through FIFO for a downstream consumer. A run collects
//   count_target points. A run that waits too long for the generator ends
//   in an error state.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   start, count_target      begin a run / number of points in the run
//   gen_pop_enable           request to the generator (high only in REQ)
//   gen_valid, gen_w..gen_z  generator handshake level and point data
//   out_w..out_z, out_valid  oldest buffered point, buffer non-empty
//   out_ready                downstream accepts the head point
//   busy, done, timeout_err  run status (timeout_err is sticky)
//   points_captured          points captured in the current run
module sphere3_point_collector #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int GAP_CYCLES     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] count_target,
  output logic        gen_pop_enable,
  input  logic        gen_valid,
  input  logic [31:0] gen_w,
  input  logic [31:0] gen_x,
  input  logic [31:0] gen_y,
  input  logic [31:0] gen_z,
  output logic [31:0] out_w,
  output logic [31:0] out_x,
  output logic [31:0] out_y,
  output logic [31:0] out_z,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done,
  output logic        timeout_err,
  output logic [15:0] points_captured
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_GAP,
    S_DONE,
    S_ERR
  } state_t;

  state_t state_reg, state_next;

  logic [AW:0]   wr_ptr_reg, rd_ptr_reg;
  logic [127:0]  mem [FIFO_DEPTH];
  logic          valid_prev_reg;
  logic [31:0]   tmo_cnt_reg;
  logic [GW-1:0] gap_cnt_reg;
  logic [15:0]   target_reg;
  logic [15:0]   captured_reg;
  logic          pop_en_reg;
  logic          timeout_err_reg;

  logic empty, full, pop, capture, start_ok, gap_last, tmo_last;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign pop   = !empty && out_ready;

  // Only a fresh rising edge counts; a level already high on REQ entry is
  // stale because valid_prev_reg is 1 on the first REQ cycle.
  assign capture  = (state_reg == S_REQ) && gen_valid && !valid_prev_reg;
  assign start_ok = start && ((state_reg == S_IDLE) || (state_reg == S_DONE) ||
                              (state_reg == S_ERR));
  assign gap_last = (gap_cnt_reg == GW'(GAP_CYCLES - 1));
  assign tmo_last = (tmo_cnt_reg == 32'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          if (count_target == 16'd0) begin
            state_next = S_DONE;
          end else if (full) begin
            // Buffer still full from an earlier run: wait in GAP for a free
            // slot so REQ is never entered with nowhere to put a point.
            state_next = S_GAP;
          end else begin
            state_next = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (capture) begin
          state_next = S_GAP;
        end else if (tmo_last) begin
          state_next = S_ERR;
        end
      end
      S_GAP: begin
        if (gap_last) begin
          if (captured_reg == target_reg) begin
            state_next = S_DONE;
          end else if (!full) begin
            state_next = S_REQ;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= S_IDLE;
      pop_en_reg      <= 1'b0;
      valid_prev_reg  <= 1'b0;
      tmo_cnt_reg     <= '0;
      gap_cnt_reg     <= '0;
      target_reg      <= '0;
      captured_reg    <= '0;
      timeout_err_reg <= 1'b0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      pop_en_reg     <= (state_next == S_REQ);
      valid_prev_reg <= gen_valid;

      // Restarts from zero on every REQ entry.
      if (state_reg == S_REQ) begin
        tmo_cnt_reg <= tmo_cnt_reg + 32'd1;
      end else begin
        tmo_cnt_reg <= '0;
      end

      // Holds at its last value while parked waiting for a free slot.
      if (state_reg != S_GAP) begin
        gap_cnt_reg <= '0;
      end else if (!gap_last) begin
        gap_cnt_reg <= gap_cnt_reg + GW'(1);
      end

      if (start_ok) begin
        target_reg <= count_target;
      end

      if (start_ok) begin
        captured_reg <= '0;
      end else if (capture && (captured_reg != 16'hFFFF)) begin
        captured_reg <= captured_reg + 16'd1;
      end

      if (start_ok) begin
        timeout_err_reg <= 1'b0;
      end else if ((state_reg == S_REQ) && (state_next == S_ERR)) begin
        timeout_err_reg <= 1'b1;
      end

      wr_ptr_reg <= wr_ptr_reg + (AW + 1)'(capture);
      rd_ptr_reg <= rd_ptr_reg + (AW + 1)'(pop);
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (capture) begin
      mem[wr_ptr_reg[AW-1:0]] <= {gen_w, gen_x, gen_y, gen_z};
    end
  end

  assign {out_w, out_x, out_y, out_z} = mem[rd_ptr_reg[AW-1:0]];
  assign out_valid       = !empty;
  assign gen_pop_enable  = pop_en_reg;
  assign busy            = (state_reg == S_REQ) || (state_reg == S_GAP);
  assign done            = (state_reg == S_DONE);
  assign timeout_err     = timeout_err_reg;
  assign points_captured = captured_reg;

endmodule

// File: tb/tb_sphere3_point_collector.sv
// Testbench for sphere3_point_collector with default parameters
// (FIFO_DEPTH=4, TIMEOUT_CYCLES=1000, GAP_CYCLES=2). A generator model
// raises gen_valid for one cycle five cycles after it sees gen_pop_enable
// and queues the expected point; a monitor pops and compares every point
// the collector hands downstream.
module tb_sphere3_point_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] count_target;
  logic        gen_pop_enable;
  logic        gen_valid;
  logic [31:0] gen_w, gen_x, gen_y, gen_z;
  logic [31:0] out_w, out_x, out_y, out_z;
  logic        out_valid;
  logic        out_ready;
  logic        busy, done, timeout_err;
  logic [15:0] points_captured;

  int checks = 0;
  int errors = 0;
  int pe_count = 0;
  int gen_mode = 0;
  int gcnt = 0;
  logic [15:0] seq = 16'd0;
  logic [127:0] exp_q[$];

  typedef struct {
    logic [15:0] target;
    int          exp_pe;
  } vec_t;
  vec_t vecs[4];

  sphere3_point_collector dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .count_target(count_target),
    .gen_pop_enable(gen_pop_enable),
    .gen_valid(gen_valid),
    .gen_w(gen_w),
    .gen_x(gen_x),
    .gen_y(gen_y),
    .gen_z(gen_z),
    .out_w(out_w),
    .out_x(out_x),
    .out_y(out_y),
    .out_z(out_z),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy(busy),
    .done(done),
    .timeout_err(timeout_err),
    .points_captured(points_captured)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_point(input logic [15:0] s);
    gen_w = {16'h1111, s};
    gen_x = {16'h2222, s};
    gen_y = {16'h3333, s};
    gen_z = {16'h4444, s};
    exp_q.push_back({gen_w, gen_x, gen_y, gen_z});
  endtask

  // Generator model: one-cycle valid pulse after five requested cycles.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (gen_mode == 0) begin
        gcnt = 0;
      end else if (rst) begin
        gcnt = 0;
        gen_valid = 1'b0;
      end else if (gen_valid) begin
        gen_valid = 1'b0;
      end else if (gen_pop_enable) begin
        gcnt++;
        if (gcnt == 5) begin
          seq = seq + 16'd1;
          set_point(seq);
          gen_valid = 1'b1;
          gcnt = 0;
        end
      end else begin
        gcnt = 0;
      end
    end
  end

  // Downstream monitor / scoreboard.
  initial begin
    logic [127:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        if (gen_pop_enable) pe_count++;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pop actual=%0h required=none", out_w);
          end else begin
            e = exp_q.pop_front();
            check("out_w", out_w, e[127:96]);
            check("out_x", out_x, e[95:64]);
            check("out_y", out_y, e[63:32]);
            check("out_z", out_z, e[31:0]);
            $display("pop point w=%h x=%h y=%h z=%h", out_w, out_x, out_y, out_z);
          end
        end
      end
    end
  end

  task automatic do_start(input logic [15:0] t);
    @(posedge clk);
    #1;
    count_target = t;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (done) break;
    end
    check({name, "_done"}, done, 1);
  endtask

  task automatic wait_drain(input string name);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if ((exp_q.size() == 0) && !out_valid) break;
    end
    check({name, "_sb_left"}, exp_q.size(), 0);
    check({name, "_out_valid"}, out_valid, 0);
  endtask

  initial begin
    logic found;
    rst = 1'b1;
    start = 1'b0;
    count_target = '0;
    gen_valid = 1'b0;
    gen_w = '0; gen_x = '0; gen_y = '0; gen_z = '0;
    out_ready = 1'b0;

    vecs[0] = '{target: 16'd2, exp_pe: 10};
    vecs[1] = '{target: 16'd1, exp_pe: 5};
    vecs[2] = '{target: 16'd3, exp_pe: 15};
    vecs[3] = '{target: 16'd0, exp_pe: 0};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_pop_en", gen_pop_enable, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_captured", points_captured, 0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven runs with the consumer always ready.
    gen_mode = 1;
    out_ready = 1'b1;
    foreach (vecs[i]) begin
      pe_count = 0;
      do_start(vecs[i].target);
      wait_done($sformatf("run%0d", i), 200);
      check($sformatf("run%0d_captured", i), points_captured, vecs[i].target);
      check($sformatf("run%0d_busy", i), busy, 0);
      check($sformatf("run%0d_terr", i), timeout_err, 0);
      wait_drain($sformatf("run%0d", i));
      check($sformatf("run%0d_pop_en_cycles", i), pe_count, vecs[i].exp_pe);
      $display("run %0d target=%0d captured=%0d pop_en_cycles=%0d", i,
               vecs[i].target, points_captured, pe_count);
    end

    // Backpressure: park in GAP with a full buffer, then drain.
    out_ready = 1'b0;
    do_start(16'd6);
    repeat (100) @(negedge clk);
    check("bp_captured", points_captured, 4);
    check("bp_busy", busy, 1);
    check("bp_pop_en", gen_pop_enable, 0);
    check("bp_out_valid", out_valid, 1);
    check("bp_done", done, 0);
    out_ready = 1'b1;
    wait_done("bp", 300);
    check("bp_captured_end", points_captured, 6);
    wait_drain("bp");
    $display("backpressure run captured=%0d", points_captured);

    // Push and pop in the same cycle at occupancy 1.
    out_ready = 1'b0;
    do_start(16'd2);
    found = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (gen_valid && gen_pop_enable && (points_captured == 16'd1)) begin
        found = 1'b1;
        break;
      end
    end
    check("simul_sync", found, 1);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("simul_captured", points_captured, 2);
    check("simul_out_valid", out_valid, 1);
    repeat (5) @(negedge clk);
    check("simul_still_one", out_valid, 1);
    check("simul_done", done, 1);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("simul_empty", out_valid, 0);
    check("simul_sb_left", exp_q.size(), 0);
    $display("simultaneous push/pop run done=%0d", done);

    // Timeout with the generator silent.
    gen_mode = 0;
    gen_valid = 1'b0;
    out_ready = 1'b1;
    pe_count = 0;
    do_start(16'd1);
    for (int n = 0; n < 1100; n++) begin
      @(negedge clk);
      if (!gen_pop_enable) break;
    end
    check("tmo_req_cycles", pe_count, 1000);
    check("tmo_err", timeout_err, 1);
    check("tmo_pop_en", gen_pop_enable, 0);
    check("tmo_busy", busy, 0);
    check("tmo_done", done, 0);
    do_start(16'd0);
    @(negedge clk);
    check("tmo_cleared", timeout_err, 0);
    check("tmo_restart_done", done, 1);
    $display("timeout run req_cycles=%0d", pe_count);

    // Stale valid level held from before the run.
    @(posedge clk);
    #1 gen_valid = 1'b1;
    do_start(16'd1);
    repeat (20) @(negedge clk);
    check("stale_captured", points_captured, 0);
    check("stale_pop_en", gen_pop_enable, 1);
    @(posedge clk);
    #1 gen_valid = 1'b0;
    @(posedge clk);
    #1;
    seq = seq + 16'd1;
    set_point(seq);
    gen_valid = 1'b1;
    @(posedge clk);
    #1 gen_valid = 1'b0;
    wait_done("stale", 20);
    check("stale_captured_end", points_captured, 1);
    wait_drain("stale");
    $display("stale level run captured=%0d", points_captured);

    // Asynchronous reset in REQ after one capture.
    gen_mode = 1;
    out_ready = 1'b0;
    do_start(16'd3);
    found = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if ((points_captured == 16'd1) && gen_pop_enable) begin
        found = 1'b1;
        break;
      end
    end
    check("mid_sync", found, 1);
    check("mid_pre_out_valid", out_valid, 1);
    #1 rst = 1'b1;
    #1;
    check("mid_pop_en", gen_pop_enable, 0);
    check("mid_out_valid", out_valid, 0);
    check("mid_busy", busy, 0);
    check("mid_done", done, 0);
    check("mid_terr", timeout_err, 0);
    check("mid_captured", points_captured, 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_idle_busy", busy, 0);
    check("mid_idle_pop_en", gen_pop_enable, 0);
    check("mid_idle_out_valid", out_valid, 0);
    $display("mid-run reset busy=%0d out_valid=%0d", busy, out_valid);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sphere3_point_collector.md
SPHERE3_POINT_COLLECTOR -- requirements
Module: sphere3_point_collector

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, point-buffer entries (power of 2, >=2).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000, maximum cycles in REQ before error.
REQ-003 SHALL have parameter GAP_CYCLES, default 2, idle cycles between requests (>=1).
REQ-004 SHALL have ports: clk in 1, sole clock; all state on its rising edge.
REQ-005 SHALL have rst in 1, asynchronous, active-high reset.
REQ-006 SHALL have start in 1, one-cycle pulse to begin a collection run.
REQ-007 SHALL have count_target in 16, number of points to collect in a run, sampled on accepted start.
REQ-008 SHALL have gen_pop_enable out 1, request to the sphere3 generator.
REQ-009 SHALL have gen_valid in 1, generator output-valid level.
REQ-010 SHALL have gen_w, gen_x, gen_y, gen_z in 32 each, generator point coordinates.
REQ-011 SHALL have out_w, out_x, out_y, out_z out 32 each, head-of-buffer point.
REQ-012 SHALL have out_valid out 1 (buffer non-empty) and out_ready in 1 (downstream accept).
REQ-013 SHALL have busy out 1, done out 1, timeout_err out 1, points_captured out 16.

Function
REQ-014 SHALL implement FSM states IDLE, REQ, GAP, DONE, ERR.
REQ-015 SHALL accept start only in IDLE, DONE or ERR; ignore start in REQ/GAP.
REQ-016 On accepted start: clear points_captured, done, timeout_err; latch count_target; go to DONE next cycle if target=0, else REQ.
REQ-017 SHALL drive gen_pop_enable=1 only in REQ (registered output).
REQ-018 SHALL detect a gen_valid rising edge (gen_valid=1, previous-cycle gen_valid=0) as a capture event; a level held high from before REQ entry SHALL NOT count.
REQ-019 On capture in REQ: push {gen_w,gen_x,gen_y,gen_z} sampled that cycle, increment points_captured, enter GAP; gen_pop_enable low the following cycle.
REQ-020 GAP SHALL last GAP_CYCLES cycles, then go to DONE if points_captured=target, else REQ if buffer not full, else stay in GAP until a slot frees.
REQ-021 REQ SHALL count cycles from entry; at TIMEOUT_CYCLES without capture go to ERR, set timeout_err sticky until next accepted start.
REQ-022 done SHALL be high exactly while in DONE; busy SHALL be high in REQ and GAP.
REQ-023 Buffer SHALL be FIFO, first-word fall-through: out_* show oldest entry, out_valid = not empty.
REQ-024 Pop SHALL occur on out_valid & out_ready; out_* are don't-care when empty.
REQ-025 Push and pop in the same cycle SHALL both take effect; occupancy unchanged.
REQ-026 REQ SHALL never be entered with buffer full, so no push is ever dropped.
REQ-027 FIFO pointers SHALL wrap modulo FIFO_DEPTH with one extra bit for full/empty distinction.
REQ-028 points_captured SHALL saturate at 16'hFFFF.
REQ-029 Buffer contents SHALL persist across DONE/ERR and a new start; only rst empties it.

Reset
REQ-030 While rst=1: state IDLE, gen_pop_enable=0, out_valid=0, busy=0, done=0, timeout_err=0, points_captured=0, FIFO pointers 0, edge-detect register 0, timeout counter 0.
REQ-031 rst asserted mid-run SHALL abort immediately and asynchronously; after release the block waits in IDLE for start.

Verification
REQ-032 Basic: target=2, generator model raises valid 5 cycles after pop_enable, out_ready=1 -> two points out in order, points_captured=2, done=1, gen_pop_enable low in GAP.
REQ-033 Backpressure: FIFO_DEPTH=4, target=6, out_ready=0 -> collector parks in GAP after 4 captures, out_valid=1; raise out_ready -> all 6 points drained in order, done=1.
REQ-034 Timeout: target=1, gen_valid held 0 -> ERR after exactly 1000 REQ cycles, timeout_err=1, gen_pop_enable=0; new start clears timeout_err.
REQ-035 Stale level: gen_valid held 1 before start -> no capture until valid falls and rises again.
REQ-036 Edges: target=0 -> done next cycle, no pop_enable; simultaneous push/pop at occupancy 1 -> occupancy stays 1.
REQ-037 Reset mid-run: rst pulsed during REQ after 1 capture -> all outputs at REQ-030 values, out_valid=0.
